// File: rtl/demux_deser_2ch_pkg.sv
// ---------------------------------------------------------------------------
// demux_deser_pkg
//   Shared constants for the two-lane demux deserialiser.
//   DEFAULT_WIDTH : default bits per assembled word
//   LANES         : number of deserialiser lanes (one per demux output)
//   CNT_W         : bit-counter width for the default word width
//   cnt_width()   : counter width for an arbitrary word width (>=2)
// ---------------------------------------------------------------------------
package demux_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int LANES         = 2;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/demux_deser_2ch_if.sv
// ---------------------------------------------------------------------------
// demux_deser_2ch_if
//   Bundles the serial input side and both word/handshake outputs.
//   slave  : deserialiser side (takes bits and acks, drives words/flags)
//   master : producer/consumer side (drives bits and acks, observes words)
//   Signals: bit_valid, sel, y0, y1, frame_clr,
//            word0, word0_valid, word0_ack, overrun0,
//            word1, word1_valid, word1_ack, overrun1
// ---------------------------------------------------------------------------
interface demux_deser_2ch_if
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             bit_valid;
    logic             sel;
    logic             y0;
    logic             y1;
    logic             frame_clr;

    logic [WIDTH-1:0] word0;
    logic             word0_valid;
    logic             word0_ack;
    logic             overrun0;

    logic [WIDTH-1:0] word1;
    logic             word1_valid;
    logic             word1_ack;
    logic             overrun1;

    modport slave (
        input  bit_valid, sel, y0, y1, frame_clr, word0_ack, word1_ack,
        output word0, word0_valid, overrun0, word1, word1_valid, overrun1
    );

    modport master (
        output bit_valid, sel, y0, y1, frame_clr, word0_ack, word1_ack,
        input  word0, word0_valid, overrun0, word1, word1_valid, overrun1
    );

endinterface

// File: rtl/demux_deser_2ch_lane.sv
// ---------------------------------------------------------------------------
// demux_deser_lane
//   One deserialiser lane: shifts accepted bits into a WIDTH-bit word, holds
//   the completed word behind a valid/ack handshake and flags dropped words.
//   clk         : clock
//   rst         : asynchronous active-high reset
//   en_i        : a bit for this lane is present this cycle
//   bit_i       : serial bit
//   frame_clr_i : flush partial word and overrun flag (word/valid kept)
//   ack_i       : consumer takes the held word
//   word_o      : held word
//   valid_o     : held word not yet consumed
//   overrun_o   : sticky, a completed word was dropped
// ---------------------------------------------------------------------------
module demux_deser_lane
    import demux_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             bit_i,
    input  logic             frame_clr_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             overrun_o
);

    localparam int LCNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [LCNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic [WIDTH-1:0]  assembled;
    logic              accept;
    logic              last_bit;
    logic              complete;

    // Value of the shift register once the current bit is included; this is
    // also what gets loaded into the word on the completing bit.
    generate
        if (MSB_FIRST) begin : g_msb
            assign assembled = {sh_q[WIDTH-2:0], bit_i};
        end else begin : g_lsb
            assign assembled = {bit_i, sh_q[WIDTH-1:1]};
        end
    endgenerate

    // frame_clr wins over a coincident bit, which is thrown away.
    assign accept   = en_i & ~frame_clr_i;
    assign last_bit = (cnt_q == LCNT_W'(WIDTH - 1));
    assign complete = accept & last_bit;

    always_comb begin
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (frame_clr_i) begin
            sh_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            sh_d  = assembled;
            cnt_d = last_bit ? '0 : cnt_q + LCNT_W'(1);
        end

        if (complete) begin
            if (valid_q && !ack_i) begin
                // Previous word still unconsumed: drop the new one.
                overrun_d = 1'b1;
            end else begin
                // Either empty, or the consumer takes the old word this edge.
                word_d  = assembled;
                valid_d = 1'b1;
            end
        end else if (valid_q && ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/demux_deser_2ch.sv
// ---------------------------------------------------------------------------
// demux_deser_2ch
//   Two-lane deserialiser behind a 1:2 bit demux. Each accepted bit goes to
//   the lane named by sel; each lane assembles its own WIDTH-bit words.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : demux_deser_2ch_if.slave (serial inputs, word outputs, handshakes)
// ---------------------------------------------------------------------------
module demux_deser_2ch
    import demux_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    demux_deser_2ch_if.slave  bus
);

    logic [LANES-1:0] lane_bit;
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] lane_ack;
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] lane_ovr;
    logic [WIDTH-1:0] lane_word [LANES];

    assign lane_bit = {bus.y1, bus.y0};
    assign lane_ack = {bus.word1_ack, bus.word0_ack};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_en[gi] = bus.bit_valid & (bus.sel == 1'(gi));

            demux_deser_lane #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .en_i        (lane_en[gi]),
                .bit_i       (lane_bit[gi]),
                .frame_clr_i (bus.frame_clr),
                .ack_i       (lane_ack[gi]),
                .word_o      (lane_word[gi]),
                .valid_o     (lane_valid[gi]),
                .overrun_o   (lane_ovr[gi])
            );
        end
    endgenerate

    assign bus.word0       = lane_word[0];
    assign bus.word0_valid = lane_valid[0];
    assign bus.overrun0    = lane_ovr[0];
    assign bus.word1       = lane_word[1];
    assign bus.word1_valid = lane_valid[1];
    assign bus.overrun1    = lane_ovr[1];

endmodule

// File: tb/tb_demux_deser_2ch.sv
// ---------------------------------------------------------------------------
// tb_demux_deser_2ch
//   Directed bench for demux_deser_2ch: dut_a is MSB-first, dut_b LSB-first.
//   Expected words are queued when a word is driven and popped when the
//   matching lane shows valid.
// ---------------------------------------------------------------------------
module tb_demux_deser_2ch;
    import demux_deser_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_deser_2ch_if #(.WIDTH(8)) ifa ();
    demux_deser_2ch_if #(.WIDTH(8)) ifb ();

    demux_deser_2ch #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    demux_deser_2ch #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] qb [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all;
        ifa.bit_valid = 1'b0; ifa.sel = 1'b0; ifa.y0 = 1'b0; ifa.y1 = 1'b0;
        ifa.frame_clr = 1'b0; ifa.word0_ack = 1'b0; ifa.word1_ack = 1'b0;
        ifb.bit_valid = 1'b0; ifb.sel = 1'b0; ifb.y0 = 1'b0; ifb.y1 = 1'b0;
        ifb.frame_clr = 1'b0; ifb.word0_ack = 1'b0; ifb.word1_ack = 1'b0;
    endtask

    // One accepted bit on dut_a; the other lane's input carries noise.
    task automatic bit_a(input logic ln, input logic b);
        ifa.bit_valid = 1'b1;
        ifa.sel       = ln;
        if (ln) begin
            ifa.y1 = b;
            ifa.y0 = 1'($urandom);
        end else begin
            ifa.y0 = b;
            ifa.y1 = 1'($urandom);
        end
        tick();
        ifa.bit_valid = 1'b0;
        ifa.y0 = 1'($urandom);
        ifa.y1 = 1'($urandom);
    endtask

    task automatic bit_b(input logic b);
        ifb.bit_valid = 1'b1;
        ifb.sel       = 1'b0;
        ifb.y0        = b;
        tick();
        ifb.bit_valid = 1'b0;
    endtask

    task automatic gap_a(input int maxn);
        repeat ($urandom_range(maxn, 0)) tick();
    endtask

    // Full MSB-first word on dut_a; push=0 for a word that must be dropped.
    task automatic word_a(input logic ln, input logic [7:0] v, input bit push);
        if (push) begin
            if (ln) q1.push_back(v);
            else    q0.push_back(v);
        end
        for (int i = 7; i >= 0; i--) bit_a(ln, v[i]);
    endtask

    // which: 0 = dut_a lane0, 1 = dut_a lane1, 2 = dut_b lane0
    task automatic check_word(input int which, input string tag);
        int         k;
        logic       v;
        logic [7:0] w;
        logic [7:0] e;
        k = 0;
        forever begin
            case (which)
                0:       begin v = ifa.word0_valid; w = ifa.word0; end
                1:       begin v = ifa.word1_valid; w = ifa.word1; end
                default: begin v = ifb.word0_valid; w = ifb.word0; end
            endcase
            if (v === 1'b1 || k >= 20) break;
            tick();
            k++;
        end
        chk({tag, "_valid"}, 32'(v), 32'd1);
        case (which)
            0:       e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
            1:       e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
            default: e = (qb.size() > 0) ? qb.pop_front() : 8'hxx;
        endcase
        chk({tag, "_word"}, 32'(w), 32'(e));
    endtask

    task automatic ack_a(input logic ln);
        if (ln) ifa.word1_ack = 1'b1;
        else    ifa.word0_ack = 1'b1;
        tick();
        ifa.word0_ack = 1'b0;
        ifa.word1_ack = 1'b0;
        chk(ln ? "ack1_clears_valid" : "ack0_clears_valid",
            32'(ln ? ifa.word1_valid : ifa.word0_valid), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] va;
        logic [7:0] vb;

        // ---------------- reset
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_word0",  32'(ifa.word0),       32'd0);
        chk("rst_valid0", 32'(ifa.word0_valid), 32'd0);
        chk("rst_ovr0",   32'(ifa.overrun0),    32'd0);
        chk("rst_word1",  32'(ifa.word1),       32'd0);
        chk("rst_valid1", 32'(ifa.word1_valid), 32'd0);
        chk("rst_ovr1",   32'(ifa.overrun1),    32'd0);
        tick();

        // ---------------- 1: 0xA5 on lane0 back-to-back
        va = 8'hA5;
        q0.push_back(va);
        for (int i = 7; i >= 0; i--) begin
            bit_a(1'b0, va[i]);
            chk("t1_valid1", 32'(ifa.word1_valid), 32'd0);
            chk("t1_ovr0",   32'(ifa.overrun0),    32'd0);
            if (i != 0) chk("t1_valid0_early", 32'(ifa.word0_valid), 32'd0);
        end
        check_word(0, "t1_lane0");
        ack_a(1'b0);

        // ---------------- 2: interleaved lanes with gaps
        va = 8'h3C;
        vb = 8'hC3;
        q0.push_back(va);
        q1.push_back(vb);
        for (int i = 7; i >= 0; i--) begin
            gap_a(2);
            bit_a(1'b0, va[i]);
            if (i == 0) begin
                check_word(0, "t2_lane0");
                chk("t2_valid1_pending", 32'(ifa.word1_valid), 32'd0);
            end
            gap_a(2);
            bit_a(1'b1, vb[i]);
            if (i == 0) check_word(1, "t2_lane1");
        end
        ack_a(1'b0);
        ack_a(1'b1);

        // ---------------- 3: second word dropped, sticky overrun
        word_a(1'b0, 8'h11, 1'b1);
        check_word(0, "t3_first");
        word_a(1'b0, 8'h22, 1'b0);
        chk("t3_word_kept",  32'(ifa.word0),       32'h11);
        chk("t3_valid_kept", 32'(ifa.word0_valid), 32'd1);
        chk("t3_ovr_set",    32'(ifa.overrun0),    32'd1);
        ack_a(1'b0);
        chk("t3_ovr_sticky", 32'(ifa.overrun0),    32'd1);
        ifa.frame_clr = 1'b1;
        tick();
        ifa.frame_clr = 1'b0;
        chk("t3_ovr_cleared", 32'(ifa.overrun0),   32'd0);

        // ---------------- 4: ack coincident with completion
        word_a(1'b0, 8'h33, 1'b1);
        check_word(0, "t4_prior");
        va = 8'h5A;
        q0.push_back(va);
        for (int i = 7; i >= 1; i--) bit_a(1'b0, va[i]);
        ifa.word0_ack = 1'b1;
        bit_a(1'b0, va[0]);
        ifa.word0_ack = 1'b0;
        check_word(0, "t4_replace");
        chk("t4_ovr", 32'(ifa.overrun0), 32'd0);
        ack_a(1'b0);

        // ---------------- 5: frame_clr flushes a partial lane1 word
        bit_a(1'b1, 1'b1);
        bit_a(1'b1, 1'b0);
        bit_a(1'b1, 1'b1);
        ifa.frame_clr = 1'b1;
        ifa.bit_valid = 1'b1;
        ifa.sel       = 1'b1;
        ifa.y1        = 1'b1;
        tick();
        ifa.frame_clr = 1'b0;
        ifa.bit_valid = 1'b0;
        vb = 8'h81;
        q1.push_back(vb);
        for (int i = 7; i >= 0; i--) begin
            bit_a(1'b1, vb[i]);
            if (i != 0) chk("t5_valid1_early", 32'(ifa.word1_valid), 32'd0);
        end
        check_word(1, "t5_lane1");

        // asynchronous reset in the middle of a lane0 word (word1 still valid)
        for (int i = 0; i < 4; i++) bit_a(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_arst_word0",  32'(ifa.word0),       32'd0);
        chk("t5_arst_valid0", 32'(ifa.word0_valid), 32'd0);
        chk("t5_arst_word1",  32'(ifa.word1),       32'd0);
        chk("t5_arst_valid1", 32'(ifa.word1_valid), 32'd0);
        chk("t5_arst_ovr1",   32'(ifa.overrun1),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        word_a(1'b0, 8'h96, 1'b1);
        check_word(0, "t5_post_rst");
        ack_a(1'b0);

        // ---------------- 6: LSB-first instance
        va = 8'b0000_0001;
        qb.push_back(va);
        bit_b(1'b1);
        for (int i = 0; i < 7; i++) bit_b(1'b0);
        check_word(2, "t6_lsb_01");
        ifb.word0_ack = 1'b1;
        tick();
        ifb.word0_ack = 1'b0;
        chk("t6_ack", 32'(ifb.word0_valid), 32'd0);
        va = 8'h96;
        qb.push_back(va);
        for (int i = 0; i < 8; i++) bit_b(va[i]);
        check_word(2, "t6_lsb_96");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
